// File: rtl/handshake_arb_pkg.sv
// Shared types and helpers for the round-robin control-token arbiter.
// Provides the rotating-priority winner search used by the top.
package handshake_arb_pkg;

   localparam int GRANT_CNT_WIDTH = 16;
   localparam int RR_MAX_IN       = 16;
   localparam int RR_IDX_W        = 4;

   typedef struct packed {
      logic                found;
      logic [RR_IDX_W-1:0] idx;
   } rr_pick_t;

   function automatic int clog2_min1(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   // First valid requester at or after ptr, wrapping modulo n.
   function automatic rr_pick_t rr_pick(
      input logic [RR_MAX_IN-1:0] valid,
      input logic [RR_IDX_W-1:0]  ptr,
      input int                   n
   );
      rr_pick_t r;
      int       j;
      r = '0;
      j = 0;
      for (int k = 0; k < RR_MAX_IN; k++) begin
         if (k < n && !r.found) begin
            j = (int'(ptr) + k) % n;
            if (valid[j[RR_IDX_W-1:0]]) begin
               r.found = 1'b1;
               r.idx   = j[RR_IDX_W-1:0];
            end
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/handshake_eager_fork_2.sv
// Two-way eager fork: tracks which of two output channels has
// already completed and reports when the shared token is fully consumed.
module handshake_eager_fork_2 (
   input  logic       clk,
   input  logic       rst,
   input  logic       valid_i,
   input  logic       clear_i,
   input  logic [1:0] ready_i,
   output logic [1:0] valid_o,
   output logic       done_o
);

   logic [1:0] sent_q, sent_d;

   assign valid_o = {2{valid_i}} & ~sent_q;
   assign done_o  = valid_i & (&(sent_q | ready_i));

   always_comb begin
      sent_d = sent_q | (valid_o & ready_i);
      if (clear_i || done_o) begin
         sent_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sent_q <= '0;
      end else begin
         sent_q <= sent_d;
      end
   end

endmodule

// File: rtl/handshake_ctrl_rr_arbiter.sv
// Round-robin arbiter for dataless control tokens with registered fork output.
// Define HANDSHAKE_ARB_GRANT_CNT_EN to add the saturating grant_count port.
module handshake_ctrl_rr_arbiter
   import handshake_arb_pkg::*;
#(
   parameter int NUM_INPUTS  = 4,
   parameter int INDEX_WIDTH = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NUM_INPUTS-1:0]  ins_valid,
   output logic [NUM_INPUTS-1:0]  ins_ready,
   output logic                   outs_valid,
   input  logic                   outs_ready,
   output logic [INDEX_WIDTH-1:0] index,
   output logic                   index_valid,
   input  logic                   index_ready
`ifdef HANDSHAKE_ARB_GRANT_CNT_EN
   ,
   output logic [GRANT_CNT_WIDTH-1:0] grant_count
`endif
);

   localparam int IW = clog2_min1(NUM_INPUTS);

   logic                 full_q, full_d;
   logic [IW-1:0]        hold_q, hold_d;
   logic [IW-1:0]        ptr_q, ptr_d;
   logic [RR_MAX_IN-1:0] valid_ext;
   logic [RR_IDX_W-1:0]  ptr_ext;
   rr_pick_t             pick;
   logic                 load, drain;
   logic [1:0]           fork_valid;

   always_comb begin
      valid_ext = '0;
      valid_ext[NUM_INPUTS-1:0] = ins_valid;
      ptr_ext = '0;
      ptr_ext[IW-1:0] = ptr_q;
      pick = rr_pick(valid_ext, ptr_ext, NUM_INPUTS);
   end

   // Gated by rst so nothing is offered while reset is held.
   assign load = rst & pick.found & (~full_q | drain);

   always_comb begin
      ins_ready = '0;
      for (int i = 0; i < NUM_INPUTS; i++) begin
         ins_ready[i] = load & (pick.idx == RR_IDX_W'(i));
      end
   end

   always_comb begin
      full_d = full_q;
      hold_d = hold_q;
      ptr_d  = ptr_q;
      if (load) begin
         full_d = 1'b1;
         hold_d = pick.idx[IW-1:0];
         ptr_d  = (int'(pick.idx) == NUM_INPUTS - 1) ? '0
                : IW'(int'(pick.idx) + 1);
      end else if (drain) begin
         full_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         full_q <= 1'b0;
         hold_q <= '0;
         ptr_q  <= '0;
      end else begin
         full_q <= full_d;
         hold_q <= hold_d;
         ptr_q  <= ptr_d;
      end
   end

   handshake_eager_fork_2 u_fork (
      .clk     (clk),
      .rst     (rst),
      .valid_i (full_q),
      .clear_i (load),
      .ready_i ({index_ready, outs_ready}),
      .valid_o (fork_valid),
      .done_o  (drain)
   );

   assign outs_valid  = fork_valid[0];
   assign index_valid = fork_valid[1];
   assign index       = INDEX_WIDTH'(hold_q);

`ifdef HANDSHAKE_ARB_GRANT_CNT_EN
   logic [GRANT_CNT_WIDTH-1:0] cnt_q, cnt_d;

   assign cnt_d = (load && cnt_q != '1) ? cnt_q + GRANT_CNT_WIDTH'(1)
                : cnt_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign grant_count = cnt_q;
`endif

endmodule
